// File: rtl/console_arbiter_if.sv
// console_arbiter_if: groups the requester handshakes, divisor-change handshake,
// the simpleuart register-write bus and the arbiter status outputs.
// Ports: slave = arbiter side (takes offers, drives uart writes);
//        master = requester/uart side (makes offers, sees uart writes).
interface console_arbiter_if;
  // requester 0 (CPU) byte offer
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  // requester 1 (trace) byte offer
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  // runtime divisor change
  logic        cfg_div_we;
  logic [31:0] cfg_div_di;
  logic        cfg_div_ready;
  // simpleuart register writes
  logic [3:0]  uart_div_we;
  logic [31:0] uart_div_di;
  logic        uart_dat_we;
  logic [31:0] uart_dat_di;
  logic        uart_dat_wait;
  // status
  logic        busy;
  logic        last_grant;

  modport slave (
    input  req0_valid, req0_data,
    output req0_ready,
    input  req1_valid, req1_data,
    output req1_ready,
    input  cfg_div_we, cfg_div_di,
    output cfg_div_ready,
    output uart_div_we, uart_div_di,
    output uart_dat_we, uart_dat_di,
    input  uart_dat_wait,
    output busy, last_grant
  );

  modport master (
    output req0_valid, req0_data,
    input  req0_ready,
    output req1_valid, req1_data,
    input  req1_ready,
    output cfg_div_we, cfg_div_di,
    input  cfg_div_ready,
    input  uart_div_we, uart_div_di,
    input  uart_dat_we, uart_dat_di,
    output uart_dat_wait,
    input  busy, last_grant
  );
endinterface

// File: rtl/console_arbiter.sv
// console_arbiter: shares one simpleuart between a CPU and a trace byte source,
// and sequences divisor writes (one after reset, then on runtime request).
// Latency: offer accepted in IDLE -> uart write starts next cycle; a byte every 2 cycles at best.
// Backpressure: readies only in IDLE; uart_dat_wait stretches WRITE indefinitely, nothing is queued.
// Ports:
//   clk, resetn  - clock (rising edge) and synchronous active-low reset
//   bus (slave)  - req0/req1 byte offers, cfg divisor offer, simpleuart div/dat
//                  write ports with dat_wait stall, busy and last_grant status
module console_arbiter #(
  parameter logic [31:0] DIV_RESET = 32'd53333
) (
  input logic              clk,
  input logic              resetn,
  console_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    DIV   = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant_q;
  logic [31:0] div_q;
  logic [31:0] dat_q;

  logic        grant_cfg;
  logic        grant0;
  logic        grant1;
  logic [3:0]  div_we;
  logic [31:0] div_di;
  logic        dat_we;

  // State register plus the values captured on a handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= INIT;
      last_grant_q <= 1'b1;   // so requester 0 wins the first contested round
      div_q        <= 32'd0;
      dat_q        <= 32'd0;
    end else begin
      state <= state_nxt;
      if (grant_cfg) begin
        div_q <= bus.cfg_div_di;
      end
      if (grant0) begin
        dat_q        <= {24'd0, bus.req0_data};
        last_grant_q <= 1'b0;
      end else if (grant1) begin
        dat_q        <= {24'd0, bus.req1_data};
        last_grant_q <= 1'b1;
      end
    end
  end

  // Next state, grants and uart write strobes.
  always_comb begin
    state_nxt = state;
    grant_cfg = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    div_we    = 4'b0000;
    div_di    = 32'd0;
    dat_we    = 1'b0;

    case (state)
      INIT: begin
        // Held quiet while resetn is still low, so a long reset yields a
        // single divisor pulse in the first cycle after release.
        if (resetn) begin
          div_we = 4'b1111;
          div_di = DIV_RESET;
        end
        state_nxt = IDLE;
      end

      IDLE: begin
        // Divisor change outranks both byte sources; between the bytes the
        // source that was not served last wins a tie.
        if (bus.cfg_div_we) begin
          grant_cfg = 1'b1;
          state_nxt = DIV;
        end else if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
          grant0    = 1'b1;
          state_nxt = WRITE;
        end else if (bus.req1_valid) begin
          grant1    = 1'b1;
          state_nxt = WRITE;
        end
      end

      DIV: begin
        div_we    = 4'b1111;
        div_di    = div_q;
        state_nxt = IDLE;
      end

      WRITE: begin
        dat_we = 1'b1;
        if (!bus.uart_dat_wait) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  assign bus.cfg_div_ready = grant_cfg;
  assign bus.req0_ready    = grant0;
  assign bus.req1_ready    = grant1;
  assign bus.uart_div_we   = div_we;
  assign bus.uart_div_di   = div_di;
  assign bus.uart_dat_we   = dat_we;
  assign bus.uart_dat_di   = dat_q;
  assign bus.busy          = (state != IDLE);
  assign bus.last_grant    = last_grant_q;

endmodule

// File: tb/tb_console_arbiter.sv
// tb_console_arbiter: directed scenarios for console_arbiter with
// hand-computed expectations; inputs change 1 time unit after the rising
// edge, outputs are sampled 1 unit later still.
module tb_console_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  console_arbiter_if bus ();

  console_arbiter #(.DIV_RESET(32'd53333)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0] rdy;
  assign rdy = {bus.req0_ready, bus.req1_ready, bus.cfg_div_ready};

  task step;
    @(posedge clk);
    #1;
  endtask

  task settle;
    #1;
  endtask

  task test_reset;
    resetn            = 1'b0;
    bus.req0_valid    = 1'b0;
    bus.req0_data     = 8'h00;
    bus.req1_valid    = 1'b0;
    bus.req1_data     = 8'h00;
    bus.cfg_div_we    = 1'b0;
    bus.cfg_div_di    = 32'd0;
    bus.uart_dat_wait = 1'b0;
    step; step; step;
    settle;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", bus.busy); end
    checks++; if (bus.last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant got %b want 1", bus.last_grant); end
    checks++; if (bus.uart_div_we !== 4'b0000) begin errors++; $display("FAIL reset_div_we got %b want 0000", bus.uart_div_we); end
    checks++; if (bus.uart_div_di !== 32'd0) begin errors++; $display("FAIL reset_div_di got %0d want 0", bus.uart_div_di); end
    checks++; if (bus.uart_dat_we !== 1'b0) begin errors++; $display("FAIL reset_dat_we got %b want 0", bus.uart_dat_we); end
    checks++; if (bus.uart_dat_di !== 32'd0) begin errors++; $display("FAIL reset_dat_di got %h want 0", bus.uart_dat_di); end
    checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL reset_ready got %b want 000", rdy); end
    // Release: the INIT divisor pulse appears in this cycle only.
    resetn = 1'b1;
    settle;
    checks++; if (bus.uart_div_we !== 4'b1111) begin errors++; $display("FAIL init_div_we got %b want 1111", bus.uart_div_we); end
    checks++; if (bus.uart_div_di !== 32'd53333) begin errors++; $display("FAIL init_div_di got %0d want 53333", bus.uart_div_di); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL init_busy got %b want 1", bus.busy); end
    step; settle;
    checks++; if (bus.uart_div_we !== 4'b0000) begin errors++; $display("FAIL init_pulse_len got %b want 0000", bus.uart_div_we); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL init_to_idle busy got %b want 0", bus.busy); end
  endtask

  task test_idle_quiet;
    for (int i = 0; i < 3; i++) begin
      settle;
      checks++; if ({bus.busy, bus.uart_dat_we, bus.uart_div_we, rdy} !== 9'd0) begin
        errors++; $display("FAIL idle_quiet cycle %0d got busy=%b dat_we=%b div_we=%b rdy=%b want all 0",
                           i, bus.busy, bus.uart_dat_we, bus.uart_div_we, rdy);
      end
      step;
    end
  endtask

  task test_round_robin;
    logic [7:0] exp_dat [3];
    logic       exp_lg  [3];
    logic [2:0] exp_rdy [3];
    exp_dat[0] = 8'h41; exp_dat[1] = 8'h42; exp_dat[2] = 8'h41;
    exp_lg[0]  = 1'b0;  exp_lg[1]  = 1'b1;  exp_lg[2]  = 1'b0;
    exp_rdy[0] = 3'b100; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100;
    bus.req0_data  = 8'h41;
    bus.req1_data  = 8'h42;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.uart_dat_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle;
      checks++; if (rdy !== exp_rdy[i]) begin errors++; $display("FAIL rr_ready round %0d got %b want %b", i, rdy, exp_rdy[i]); end
      step; settle;
      checks++; if (bus.uart_dat_we !== 1'b1) begin errors++; $display("FAIL rr_dat_we round %0d got %b want 1", i, bus.uart_dat_we); end
      checks++; if (bus.uart_dat_di !== {24'd0, exp_dat[i]}) begin errors++; $display("FAIL rr_dat_di round %0d got %h want %h", i, bus.uart_dat_di, exp_dat[i]); end
      checks++; if (bus.last_grant !== exp_lg[i]) begin errors++; $display("FAIL rr_last_grant round %0d got %b want %b", i, bus.last_grant, exp_lg[i]); end
      checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL rr_ready_in_write round %0d got %b want 000", i, rdy); end
      if (i == 2) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      step; settle;
      checks++; if (bus.uart_dat_we !== 1'b0) begin errors++; $display("FAIL rr_dat_we_drop round %0d got %b want 0", i, bus.uart_dat_we); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_end_busy got %b want 0", bus.busy); end
  endtask

  task test_wait_stall;
    int cnt;
    cnt = 0;
    bus.req1_data  = 8'h55;
    bus.req1_valid = 1'b1;
    bus.uart_dat_wait = 1'b1;
    settle;
    checks++; if (rdy !== 3'b010) begin errors++; $display("FAIL stall_accept got %b want 010", rdy); end
    step;
    // Offers made while the write is stalled must be ignored.
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h77;
    bus.cfg_div_we = 1'b1;
    bus.cfg_div_di = 32'd7;
    for (int i = 0; i < 20; i++) begin
      settle;
      cnt += int'(bus.uart_dat_we);
      checks++; if (bus.uart_dat_we !== 1'b1 || bus.uart_dat_di !== 32'h55) begin
        errors++; $display("FAIL stall_hold cycle %0d got we=%b di=%h want we=1 di=55", i, bus.uart_dat_we, bus.uart_dat_di);
      end
      checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL stall_ready cycle %0d got %b want 000", i, rdy); end
      step;
    end
    bus.uart_dat_wait = 1'b0;
    bus.req0_valid = 1'b0;
    bus.cfg_div_we = 1'b0;
    settle;
    cnt += int'(bus.uart_dat_we);
    checks++; if (bus.uart_dat_di !== 32'h55) begin errors++; $display("FAIL stall_last_di got %h want 55", bus.uart_dat_di); end
    step; settle;
    checks++; if (bus.uart_dat_we !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL stall_done got we=%b busy=%b want 0 0", bus.uart_dat_we, bus.busy);
    end
    checks++; if (bus.uart_div_we !== 4'b0000) begin errors++; $display("FAIL stall_cfg_not_queued got %b want 0000", bus.uart_div_we); end
    checks++; if (cnt !== 21) begin errors++; $display("FAIL stall_we_cycles got %0d want 21", cnt); end
    checks++; if (bus.last_grant !== 1'b1) begin errors++; $display("FAIL stall_last_grant got %b want 1", bus.last_grant); end
  endtask

  task test_cfg_priority;
    bus.cfg_div_we = 1'b1;
    bus.cfg_div_di = 32'd1667;
    bus.req0_data  = 8'h10;
    bus.req0_valid = 1'b1;
    settle;
    checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL cfg_prio_ready got %b want 001", rdy); end
    step;
    bus.cfg_div_we = 1'b0;
    settle;
    checks++; if (bus.uart_div_we !== 4'b1111) begin errors++; $display("FAIL cfg_div_we got %b want 1111", bus.uart_div_we); end
    checks++; if (bus.uart_div_di !== 32'd1667) begin errors++; $display("FAIL cfg_div_di got %0d want 1667", bus.uart_div_di); end
    checks++; if (rdy !== 3'b000 || bus.uart_dat_we !== 1'b0) begin
      errors++; $display("FAIL cfg_div_quiet got rdy=%b dat_we=%b want 000 0", rdy, bus.uart_dat_we);
    end
    step; settle;
    checks++; if (bus.uart_div_we !== 4'b0000) begin errors++; $display("FAIL cfg_div_pulse_len got %b want 0000", bus.uart_div_we); end
    checks++; if (rdy !== 3'b100) begin errors++; $display("FAIL cfg_then_req0 got %b want 100", rdy); end
    step;
    bus.req0_valid = 1'b0;
    settle;
    checks++; if (bus.uart_dat_we !== 1'b1 || bus.uart_dat_di !== 32'h10) begin
      errors++; $display("FAIL cfg_req0_write got we=%b di=%h want 1 10", bus.uart_dat_we, bus.uart_dat_di);
    end
    checks++; if (bus.last_grant !== 1'b0) begin errors++; $display("FAIL cfg_req0_grant got %b want 0", bus.last_grant); end
    step; settle;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cfg_end_busy got %b want 0", bus.busy); end
  endtask

  task test_reset_mid_write;
    bus.req1_valid = 1'b0;
    bus.req0_data  = 8'h33;
    bus.req0_valid = 1'b1;
    bus.uart_dat_wait = 1'b1;
    settle;
    checks++; if (rdy !== 3'b100) begin errors++; $display("FAIL rmw_accept got %b want 100", rdy); end
    step;
    bus.req0_valid = 1'b0;
    settle;
    checks++; if (bus.uart_dat_we !== 1'b1 || bus.uart_dat_di !== 32'h33) begin
      errors++; $display("FAIL rmw_write got we=%b di=%h want 1 33", bus.uart_dat_we, bus.uart_dat_di);
    end
    resetn = 1'b0;
    step; settle;
    checks++; if (bus.uart_dat_we !== 1'b0 || bus.uart_dat_di !== 32'd0) begin
      errors++; $display("FAIL rmw_abort got we=%b di=%h want 0 0", bus.uart_dat_we, bus.uart_dat_di);
    end
    checks++; if (bus.busy !== 1'b1 || bus.last_grant !== 1'b1 || bus.uart_div_we !== 4'b0000) begin
      errors++; $display("FAIL rmw_reset_state got busy=%b lg=%b div_we=%b want 1 1 0000", bus.busy, bus.last_grant, bus.uart_div_we);
    end
    resetn = 1'b1;
    settle;
    checks++; if (bus.uart_div_we !== 4'b1111 || bus.uart_div_di !== 32'd53333) begin
      errors++; $display("FAIL rmw_init_pulse got we=%b di=%0d want 1111 53333", bus.uart_div_we, bus.uart_div_di);
    end
    step;
    bus.uart_dat_wait = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle;
      checks++; if (bus.uart_dat_we !== 1'b0 || bus.uart_dat_di !== 32'd0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL rmw_no_retry cycle %0d got we=%b di=%h busy=%b want 0 0 0", i, bus.uart_dat_we, bus.uart_dat_di, bus.busy);
      end
      step;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_idle_quiet;
    test_round_robin;
    test_wait_stall;
    test_cfg_priority;
    test_reset_mid_write;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_arbiter.md
CONSOLE_ARBITER -- requirements
Module: console_arbiter

Interface
REQ-001 SHALL have parameter DIV_RESET, default 53333, UART divisor written after reset (16 MHz / 300 baud).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0_valid  input  1 and req0_data  input  8  requester 0 (CPU) byte offer.
REQ-005 SHALL have port req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-006 SHALL have ports req1_valid  input  1 and req1_data  input  8  requester 1 (trace) byte offer.
REQ-007 SHALL have port req1_ready  output  1  requester 1 byte accepted this cycle.
REQ-008 SHALL have ports cfg_div_we  input  1 and cfg_div_di  input  32  runtime divisor change request.
REQ-009 SHALL have port cfg_div_ready  output  1  divisor request accepted this cycle.
REQ-010 SHALL have ports uart_div_we  output  4 and uart_div_di  output  32  to simpleuart divisor register.
REQ-011 SHALL have ports uart_dat_we  output  1 and uart_dat_di  output  32  to simpleuart data register.
REQ-012 SHALL have port uart_dat_wait  input  1  simpleuart busy stall.
REQ-013 SHALL have ports busy  output  1 (state != IDLE) and last_grant  output  1 (index of last served requester).

Function
REQ-014 SHALL implement states INIT, IDLE, DIV, WRITE.
REQ-015 INIT SHALL last exactly one cycle: uart_div_we=4'b1111, uart_div_di=DIV_RESET, then IDLE.
REQ-016 A handshake SHALL complete in a cycle where valid and ready are both high; ready outputs SHALL be combinational from state, valids and last_grant.
REQ-017 Ready outputs SHALL be high only in IDLE; at most one of req0_ready, req1_ready, cfg_div_ready SHALL be high per cycle.
REQ-018 In IDLE, cfg_div_we SHALL have priority over both byte requesters.
REQ-019 On cfg handshake SHALL latch cfg_div_di, enter DIV; DIV SHALL drive uart_div_we=4'b1111 with latched value for one cycle, then IDLE.
REQ-020 Byte arbitration SHALL be round-robin: single valid wins; both valid -> requester != last_grant wins.
REQ-021 On byte handshake SHALL latch data zero-extended into uart_dat_di[31:0], update last_grant, enter WRITE.
REQ-022 In WRITE uart_dat_we SHALL be 1 and uart_dat_di stable; the write completes on the first WRITE cycle with uart_dat_wait=0.
REQ-023 Following completion, uart_dat_we SHALL be 0 and state IDLE on the next cycle; WRITE duration unbounded while wait=1.
REQ-024 Minimum spacing SHALL be: handshake cycle, >=1 WRITE cycle, IDLE; back-to-back bytes every 2 cycles when wait=0.
REQ-025 uart_div_we SHALL be 0 in every state except INIT and DIV; uart_dat_we SHALL be 0 outside WRITE.
REQ-026 Valid deasserted without handshake SHALL be legal and cause no state change.
REQ-027 Inputs in non-IDLE states SHALL be ignored (not queued).

Reset
REQ-028 resetn=0 sampled at a clock edge SHALL force state INIT, last_grant=1, uart_dat_we=0, uart_div_we=0, uart_dat_di=0, uart_div_di=0, all ready=0, busy=1.
REQ-029 Reset mid-WRITE or mid-DIV SHALL abort; the pending byte/divisor SHALL be discarded, not retried.
REQ-030 After resetn rises, INIT SHALL execute once, so first req0 offer is served ahead of req1 when both valid.

Verification
REQ-031 Release reset -> uart_div_we=4'b1111, uart_div_di=53333 for exactly 1 cycle, then busy=0.
REQ-032 req0 0x41 and req1 0x42 valid together, wait=0 -> writes 0x41, then 0x42, then 0x41 alternating; last_grant 0,1,0.
REQ-033 req1 0x55 with wait=1 for 20 cycles -> uart_dat_we high 21 cycles, uart_dat_di=0x55 throughout, no ready asserted.
REQ-034 cfg_div_we with 1667 and req0 valid same cycle -> cfg_div_ready=1, req0_ready=0; divisor pulse 1667, then req0 served.
REQ-035 resetn=0 during WRITE of 0x33 -> uart_dat_we=0 next cycle, INIT divisor pulse 53333, 0x33 never reappears.
